// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit adder that adds one 4-bit carry-lookahead nibble per cycle.
// Latency: operands accepted at edge t give out_valid after edge t+NCHUNK.
// Backpressure: in_ready low in RUN/DONE; the result is held in DONE until out_ready.

// 4-bit carry-lookahead slice: all nibble carries come from generate/propagate terms.
module cla_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / 4;
  // Wide enough to hold NCHUNK itself, so the final increment never wraps.
  localparam int KW     = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic             r_c_msb;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_nib_mask;
  logic [WIDTH-1:0] w_nib_val;
  logic [WIDTH-1:0] w_sum_upd;

  // Shift-based nibble select keeps the index in range even when k has reached NCHUNK.
  assign w_a_nib = 4'(r_a >> (4 * r_k));
  assign w_b_nib = 4'(r_b >> (4 * r_k));
  assign w_last  = (r_k == KW'(NCHUNK - 1));

  cla_4bit u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_c    (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Merge the new slice result into result nibble k, leaving other nibbles intact.
  assign w_nib_mask = WIDTH'(4'hF) << (4 * r_k);
  assign w_nib_val  = WIDTH'(w_slice_sum) << (4 * r_k);
  assign w_sum_upd  = (r_sum & ~w_nib_mask) | w_nib_val;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN for NCHUNK cycles, DONE until consumed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: latch operands on accept, then one nibble per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_c_msb <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_k     <= '0;
            r_sum   <= '0;
            r_c_msb <= 1'b0;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_upd;
          r_carry <= w_slice_cout;
          r_k     <= r_k + KW'(1);
          // Carry into the MSB recovered from the top bit's sum equation.
          if (w_last) begin
            r_c_msb <= w_a_nib[3] ^ w_b_nib[3] ^ w_slice_sum[3];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_carry;
  assign Ovf  = r_c_msb ^ r_carry;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder at WIDTH=16: directed vectors,
// reset-abort sequence and random operations against an arithmetic model.
module tb_cla_seq_adder;

  localparam int W      = 16;
  localparam int NCHUNK = W / 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;
  logic         busy;

  int checks;
  int errors;
  int hs_count;
  int exp_hs;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every completed result handshake.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) hs_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    int           hold;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  // Run one operation: accept, measure latency, check result, hold, consume.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input int hold, input string tag,
                       input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      fail_timeout({tag, " in_ready"});
      return;
    end
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    Cin       = cin;
    out_ready = 1'($urandom % 2);
    @(posedge clk);
    @(negedge clk);
    exp_hs++;
    check({tag, " run status"}, {62'd0, busy, in_ready}, 64'b10);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      in_valid  = 1'($urandom % 2);
      A         = W'($urandom);
      B         = W'($urandom);
      Cin       = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!out_valid) begin
      fail_timeout({tag, " out_valid"});
      in_valid  = 1'b0;
      out_ready = 1'b0;
      return;
    end
    check({tag, " latency"}, 64'(cyc), 64'(NCHUNK));
    check({tag, " sum"}, 64'(Sum), 64'(exp_sum));
    check({tag, " cout"}, 64'(Cout), 64'(exp_cout));
    check({tag, " ovf"}, 64'(Ovf), 64'(exp_ovf));
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'($urandom % 2);
      A         = W'($urandom);
      B         = W'($urandom);
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold"}, {out_valid, in_ready, Cout, Ovf, Sum},
            {1'b1, 1'b0, exp_cout, exp_ovf, exp_sum});
    end
    // Consume with in_valid high: no operand may be accepted on that edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A         = W'($urandom);
    B         = W'($urandom);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, " consumed"}, {61'd0, out_valid, busy, in_ready}, 64'b001);
  endtask

  // Reference: plain wide addition; overflow from operand/result sign rule.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         rc, ec, eo;
    int           seen;

    checks    = 0;
    errors    = 0;
    hs_count  = 0;
    exp_hs    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0};
    vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 5};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 2};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1};
    vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0};

    #1;
    check("reset outputs", {58'd0, in_ready, out_valid, busy, Cout, Ovf, 1'b0},
          {58'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset sum", 64'(Sum), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold, $sformatf("vec%0d", i),
            vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // Reset during the 2nd RUN cycle aborts the operation.
    in_valid = 1'b1;
    A        = 16'h9999;
    B        = 16'h6667;
    Cin      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort outputs", {59'd0, in_ready, out_valid, busy, Cout, Ovf},
          {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("abort sum", 64'(Sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort no out_valid", 64'(seen), 64'd0);
    do_op(16'h0003, 16'h0001, 1'b0, 0, "post-abort", 16'h0004, 1'b0, 1'b0);

    // Random back-to-back operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom % 2);
      if (i % 8 == 0) rb = ~ra;
      model(ra, rb, rc, es, ec, eo);
      do_op(ra, rb, rc, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i), es, ec, eo);
    end

    @(negedge clk);
    check("handshake count", 64'(hs_count), 64'(exp_hs));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
